adder_pipe_n_bit: RTL and testbench

- Parametrised successor to the team's 4-bit dataflow adder: WIDTH-bit add/subtract split into STAGES carry-chained chunks, one chunk per pipeline stage.
- Streaming valid/ready interface; full throughput of one operation per clock; latency STAGES cycles.
- Sits in the datapath library as the standard registered adder for wide operands where a single-cycle ripple chain misses timing.

---
 rtl/adder_pipe_n_bit_if.sv | 27 ++
 rtl/adder_pipe_n_bit.sv | 112 +++++++++++
 tb/tb_adder_pipe_n_bit.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_pipe_n_bit_if.sv
// Streaming operand/result bundle for adder_pipe_n_bit.
// master = producer/consumer side (bench or upstream logic); slave = the adder.
interface adder_pipe_n_bit_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, A, B, cin, sub, out_ready,
    input  in_ready, out_valid, Sum, cout, ovf
  );

  modport slave (
    input  in_valid, A, B, cin, sub, out_ready,
    output in_ready, out_valid, Sum, cout, ovf
  );
endinterface

// File: rtl/adder_pipe_n_bit.sv
// WIDTH-bit add/subtract pipelined as STAGES carry-chained chunks, valid/ready streaming.
// Define ADDER_PIPE_SAT_EN to clamp Sum to the signed extreme on overflow.
module adder_pipe_n_bit #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic               clk,
  input logic               rst_n,
  adder_pipe_n_bit_if.slave bus
);
  localparam int CW = WIDTH / STAGES;

  logic             w_adv;
  logic [WIDTH-1:0] w_bx_in;
  logic             w_cx_in;
  logic             r_out_v;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  assign w_adv         = !r_out_v || bus.out_ready;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_out_v;
  assign bus.Sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

  assign w_bx_in = bus.sub ? ~bus.B : bus.B;
  assign w_cx_in = bus.sub ? ~bus.cin : bus.cin;

  // Stage k sees only the operand chunks not yet consumed (k..STAGES-1) and
  // the finished low sum chunks (0..k-1); register widths shrink/grow to match.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int UW = WIDTH - k * CW;
    localparam int SW = (k + 1) * CW;

    logic          w_vi;
    logic [UW-1:0] w_a;
    logic [UW-1:0] w_bx;
    logic          w_ci;
    logic [CW:0]   w_t;
    logic [SW-1:0] w_s;

    if (k == 0) begin : g_in
      assign w_vi = bus.in_valid;
      assign w_a  = bus.A;
      assign w_bx = w_bx_in;
      assign w_ci = w_cx_in;
      assign w_s  = w_t[CW-1:0];
    end else begin : g_in
      assign w_vi = g_st[k-1].g_mid.r_v;
      assign w_a  = g_st[k-1].g_mid.r_a;
      assign w_bx = g_st[k-1].g_mid.r_bx;
      assign w_ci = g_st[k-1].g_mid.r_c;
      assign w_s  = {w_t[CW-1:0], g_st[k-1].g_mid.r_s};
    end

    assign w_t = {1'b0, w_a[CW-1:0]} + {1'b0, w_bx[CW-1:0]} + (CW+1)'(w_ci);

    if (k < STAGES - 1) begin : g_mid
      logic             r_v;
      logic             r_c;
      logic [UW-CW-1:0] r_a;
      logic [UW-CW-1:0] r_bx;
      logic [SW-1:0]    r_s;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_v  <= 1'b0;
          r_c  <= 1'b0;
          r_a  <= '0;
          r_bx <= '0;
          r_s  <= '0;
        end else if (w_adv) begin
          r_v  <= w_vi;
          r_c  <= w_t[CW];
          r_a  <= w_a[UW-1:CW];
          r_bx <= w_bx[UW-1:CW];
          r_s  <= w_s;
        end
      end
    end else begin : g_last
      logic             w_ovf;
      logic [WIDTH-1:0] w_res;

      // Top bit of the last chunk is the operand MSB.
      assign w_ovf = (w_a[UW-1] == w_bx[UW-1]) && (w_s[WIDTH-1] != w_a[UW-1]);

`ifdef ADDER_PIPE_SAT_EN
      assign w_res = !w_ovf   ? w_s :
                     w_a[UW-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                 {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign w_res = w_s;
`endif

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_out_v <= 1'b0;
          r_sum   <= '0;
          r_cout  <= 1'b0;
          r_ovf   <= 1'b0;
        end else if (w_adv) begin
          r_out_v <= w_vi;
          r_sum   <= w_res;
          r_cout  <= w_t[CW];
          r_ovf   <= w_ovf;
        end
      end
    end
  end
endmodule

// File: tb/tb_adder_pipe_n_bit.sv
// Self-checking bench for adder_pipe_n_bit (WIDTH=16, STAGES=4); honours ADDER_PIPE_SAT_EN.
module tb_adder_pipe_n_bit;
  localparam int W = 16;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_pipe_n_bit_if #(.WIDTH(W)) ifc ();

  adder_pipe_n_bit #(.WIDTH(W), .STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  logic [17:0] q[$];   // {ovf, cout, sum} of accepted operations, in order

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: integer arithmetic on the unsigned and signed interpretations.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic s);
    int ua, ub, sa, sb, ures, sres;
    logic co, ov;
    logic [15:0] sm;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!s) begin
      ures = ua + ub + int'(ci);
      sres = sa + sb + int'(ci);
      co   = (ures > 65535);
    end else begin
      ures = ua - ub - int'(ci);
      sres = sa - sb - int'(ci);
      co   = (ures >= 0);
    end
    ov = (sres > 32767) || (sres < -32768);
    sm = ures[15:0];
`ifdef ADDER_PIPE_SAT_EN
    if (ov) sm = (sres > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {ov, co, sm};
  endfunction

  // Scoreboard: sampled on the falling edge, transfers happen at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      if (ifc.out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out", 32'(ifc.Sum), 32'hDEAD);
        end else begin
          check("sb_sum",  32'(ifc.Sum),  32'(q[0][15:0]));
          check("sb_cout", 32'(ifc.cout), 32'(q[0][16]));
          check("sb_ovf",  32'(ifc.ovf),  32'(q[0][17]));
          if (ifc.out_ready) void'(q.pop_front());
        end
      end
      if (ifc.in_valid && ifc.in_ready)
        q.push_back(model(ifc.A, ifc.B, ifc.cin, ifc.sub));
    end
  end

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic s);
    ifc.A = a;
    ifc.B = b;
    ifc.cin = ci;
    ifc.sub = s;
    ifc.in_valid = 1'b1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic s);
    bit acc = 0;
    drive(a, b, ci, s);
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      acc = ifc.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    ifc.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
  endtask

  // One operation into an empty pipe; checks the exact latency and result.
  task automatic apply_vec(input vec_t v, input string nm);
    @(posedge clk);
    #1;
    drive(v.a, v.b, v.cin, v.sub);
    check({nm, "_in_ready"}, 32'(ifc.in_ready), 32'd1);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    for (int c = 0; c < S; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      check({nm, "_out_valid"}, 32'(ifc.out_valid), 32'(c == S - 1));
    end
    check({nm, "_sum"},  32'(ifc.Sum),  32'(v.sum));
    check({nm, "_cout"}, 32'(ifc.cout), 32'(v.cout));
    check({nm, "_ovf"},  32'(ifc.ovf),  32'(v.ovf));
  endtask

  vec_t tbl[6];
  logic [15:0] corners[6];

  initial begin
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
`ifdef ADDER_PIPE_SAT_EN
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
`else
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
`endif
    tbl[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
    tbl[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    corners = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001, 16'h00FF};

    ifc.in_valid = 1'b0;
    ifc.A = '0;
    ifc.B = '0;
    ifc.cin = 1'b0;
    ifc.sub = 1'b0;
    ifc.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("rst_sum",       32'(ifc.Sum),       32'd0);
    check("rst_cout",      32'(ifc.cout),      32'd0);
    check("rst_ovf",       32'(ifc.ovf),       32'd0);
    check("rst_in_ready",  32'(ifc.in_ready),  32'd1);
    rst_n = 1'b1;

    // Directed vectors with exact latency
    for (int i = 0; i < 6; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

    // Throughput: 8 back-to-back operations, results on consecutive cycles
    for (int j = 0; j < 12; j++) begin
      @(posedge clk);
      #1;
      if (j < 8) drive(16'(j), 16'h00FF, 1'b0, 1'b0);
      else ifc.in_valid = 1'b0;
      check($sformatf("tput_valid%0d", j), 32'(ifc.out_valid), 32'(j >= S));
      if (j >= S)
        check($sformatf("tput_sum%0d", j), 32'(ifc.Sum), 32'(16'h00FF + 16'(j - S)));
    end
    drain();

    // Backpressure: fill pipe with out_ready low, hold 5 cycles, release
    @(posedge clk);
    #1;
    ifc.out_ready = 1'b0;
    for (int i = 0; i < S; i++)
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    for (int c = 0; c < 5; c++) begin
      check("bp_in_ready",  32'(ifc.in_ready),  32'd0);
      check("bp_out_valid", 32'(ifc.out_valid), 32'd1);
      check("bp_depth",     32'(q.size()),      32'(S));
      @(posedge clk);
      #1;
    end
    ifc.out_ready = 1'b1;
    drain();

    // Randomized traffic with random gaps and backpressure
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      ifc.out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(3) != 0)
        drive(($urandom_range(3) == 0) ? corners[$urandom_range(5)] : 16'($urandom),
              ($urandom_range(3) == 0) ? corners[$urandom_range(5)] : 16'($urandom),
              1'($urandom), 1'($urandom));
      else
        ifc.in_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.out_ready = 1'b1;
    drain();

    // Reset with three operations in flight
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(16'h1111 * 16'(i + 1), 16'h0101, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_out_valid", 32'(ifc.out_valid), 32'd0);
    check("mrst_sum",       32'(ifc.Sum),       32'd0);
    check("mrst_in_ready",  32'(ifc.in_ready),  32'd1);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      check("mrst_no_stale", 32'(ifc.out_valid), 32'd0);
    end
    apply_vec(tbl[5], "post_rst");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
